// File: rtl/simplecpu_loader_pkg.sv
// Shared constants, types and helpers for the simplecpu Wishbone loader.
package simplecpu_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int LANES      = 4;

  // Register offsets inside the 32-byte window
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_LOAD   = 5'h08;
  localparam logic [4:0] OFF_PTR    = 5'h0C;
  localparam logic [4:0] OFF_OUT    = 5'h10;

  // Register bit positions
  localparam int CTRL_HOLD_BIT   = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;
  localparam int STATUS_PTR_LSB  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wb_state_t;

  // Index of the lowest enabled byte lane (0 when no lane is enabled)
  function automatic logic [1:0] lowest_lane(input logic [LANES-1:0] mask);
    lowest_lane = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lane = 2'(i);
    end
  endfunction

endpackage

// File: rtl/simplecpu_wb_loader_if.sv
// Wishbone slave bus bundle between the management SoC and the loader.
interface simplecpu_wb_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/simplecpu_load_serializer.sv
// Turns a latched bus word into one load_ram pulse per enabled byte lane,
// lowest lane first, and owns the auto-incrementing RAM pointer.
module simplecpu_load_serializer
  import simplecpu_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      load_start,
  input  logic [LANES*DATA_W-1:0]   load_word,
  input  logic [LANES-1:0]          load_sel,
  input  logic                      ptr_wr,
  input  logic [ADDR_W-1:0]         ptr_wdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ptr,
  output logic                      load_ram,
  output logic [ADDR_W-1:0]         load_addr,
  output logic [DATA_W-1:0]         load_data
);

  logic [DATA_W-1:0] lane_reg [LANES];
  logic [DATA_W-1:0] src_lane [LANES];
  logic [LANES-1:0]  mask_reg;
  logic [LANES-1:0]  src_mask;
  logic [LANES-1:0]  next_mask;
  logic [1:0]        sel_idx;
  logic              emit;
  logic [ADDR_W-1:0] ptr_reg;
  logic              load_ram_reg;
  logic [ADDR_W-1:0] load_addr_reg;
  logic [DATA_W-1:0] load_data_reg;

  // A fresh word bypasses the lane store so its first byte goes out next cycle
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign src_lane[gi] = load_start ? load_word[gi*DATA_W +: DATA_W] : lane_reg[gi];
  end

  // Pick the lowest pending lane; disabled lanes never cost a cycle
  always_comb begin
    src_mask  = load_start ? load_sel : mask_reg;
    emit      = |src_mask;
    sel_idx   = lowest_lane(src_mask);
    next_mask = src_mask & ~(4'b0001 << sel_idx);
  end

  // Lane data store (no reset needed: qualified by the mask)
  always_ff @(posedge clk) begin
    lane_reg <= src_lane;
  end

  // Pending mask, output strobe and pointer
  always_ff @(posedge clk) begin
    if (srst) begin
      mask_reg      <= '0;
      load_ram_reg  <= 1'b0;
      load_addr_reg <= '0;
      load_data_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      mask_reg     <= emit ? next_mask : '0;
      load_ram_reg <= emit;
      if (emit) begin
        load_addr_reg <= ptr_reg;
        load_data_reg <= src_lane[sel_idx];
        ptr_reg       <= ptr_reg + 1'b1;
      end else if (ptr_wr) begin
        ptr_reg <= ptr_wdata;
      end
    end
  end

  // Busy means bytes still wait behind the one currently on the outputs
  assign busy      = |mask_reg;
  assign ptr       = ptr_reg;
  assign load_ram  = load_ram_reg;
  assign load_addr = load_addr_reg;
  assign load_data = load_data_reg;

endmodule

// File: rtl/simplecpu_wb_loader.sv
// Wishbone slave for simplecpu: program RAM loading, CPU reset hold and
// output-port readback.
module simplecpu_wb_loader
  import simplecpu_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DATA_W    = DATA_W_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  simplecpu_wb_loader_if.slave    wb,
  input  logic [7:0]              cpu_out_port,
  output logic                    cpu_reset,
  output logic                    load_ram,
  output logic [ADDR_W-1:0]       load_addr,
  output logic [DATA_W-1:0]       load_data
);

  wb_state_t         state_reg, state_next;
  logic              hold_reg, hold_next;
  logic              err_reg, err_next;
  logic              cpu_reset_reg;
  logic [31:0]       dat_reg, dat_next;
  logic [31:0]       rd_data;
  logic [4:0]        offset;
  logic              hit, req, wait_busy, accept, wr;
  logic              load_start, ptr_wr, busy;
  logic [ADDR_W-1:0] ptr;

  assign offset    = wb.wbs_adr_i[4:0];
  assign hit       = (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req       = wb.wbs_cyc_i & wb.wbs_stb_i;
  // LOAD and PTR writes stall while bytes are pending so addresses stay in order
  assign wait_busy = wb.wbs_we_i && busy && (offset == OFF_LOAD || offset == OFF_PTR);

  // Ack FSM next state plus register write decode
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req && hit && !wait_busy) begin
          accept     = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    wr         = accept & wb.wbs_we_i;
    load_start = wr && (offset == OFF_LOAD) && hold_reg && (|wb.wbs_sel_i);
    ptr_wr     = wr && (offset == OFF_PTR);

    hold_next = hold_reg;
    err_next  = err_reg;
    if (wr && offset == OFF_CTRL) begin
      hold_next = wb.wbs_dat_i[CTRL_HOLD_BIT];
      err_next  = 1'b0;
    end
    if (wr && offset == OFF_LOAD && !hold_reg) begin
      err_next = 1'b1;
    end
  end

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_CTRL:   rd_data[CTRL_HOLD_BIT] = hold_reg;
      OFF_STATUS: begin
        rd_data[STATUS_BUSY_BIT]           = busy;
        rd_data[STATUS_ERR_BIT]            = err_reg;
        rd_data[STATUS_PTR_LSB +: ADDR_W]  = ptr;
      end
      OFF_PTR:    rd_data[ADDR_W-1:0]      = ptr;
      OFF_OUT:    rd_data[7:0]             = cpu_out_port;
      default:    rd_data = '0;
    endcase
    dat_next = (accept && !wb.wbs_we_i) ? rd_data : 32'd0;
  end

  // State, control registers and registered bus outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= 1'b1;
      err_reg       <= 1'b0;
      dat_reg       <= '0;
      cpu_reset_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      err_reg       <= err_next;
      dat_reg       <= dat_next;
      cpu_reset_reg <= hold_reg | busy;
    end
  end

  simplecpu_load_serializer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk        (wb_clk_i),
    .srst       (wb_rst_i),
    .load_start (load_start),
    .load_word  (wb.wbs_dat_i),
    .load_sel   (wb.wbs_sel_i),
    .ptr_wr     (ptr_wr),
    .ptr_wdata  (wb.wbs_dat_i[ADDR_W-1:0]),
    .busy       (busy),
    .ptr        (ptr),
    .load_ram   (load_ram),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  assign wb.wbs_ack_o = (state_reg == ST_ACK);
  assign wb.wbs_dat_o = dat_reg;
  assign cpu_reset    = cpu_reset_reg;

endmodule
